// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, zero-latency IF lookup and EX-stage resolution.
// Lookup is combinational from registered state; updates land on the next rising edge and have no backpressure.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_cti_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_pc_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] cti_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        cti_cnt_q, miss_cnt_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [31:0]      if_seq_pc;

  assign if_idx       = pc_if_i[IDX_W+1:2];
  assign if_tag       = pc_if_i[31:IDX_W+2];
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_seq_pc    = pc_if_i + 32'd4;
  assign pred_taken_o = if_hit & ctr_q[if_idx][1];
  assign pred_pc_o    = pred_taken_o ? target_q[if_idx] : if_seq_pc;

  // Execute-side resolution
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  logic             act_taken;
  logic             stale_hit;

  assign ex_idx    = ex_pc_i[IDX_W+1:2];
  assign ex_tag    = ex_pc_i[31:IDX_W+2];
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd       = ex_valid_i & ex_is_cti_i;
  assign act_taken = ex_is_cti_i & ex_taken_i;
  assign stale_hit = ex_valid_i & ~ex_is_cti_i & ex_pred_taken_i;

  // A non-CTI is never "taken", so one comparison covers both the CTI and stale-entry cases
  assign mispredict_o  = rst_ni & ex_valid_i &
                         ((act_taken != ex_pred_taken_i) |
                          (act_taken & (ex_target_i != ex_pred_pc_i)));
  assign redirect_pc_o = !rst_ni  ? 32'd0 :
                         act_taken ? ex_target_i : ex_pc_i + 32'd4;
  assign cti_cnt_o     = cti_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

  // Next-state for the single entry touched this cycle
  logic             we;
  logic             valid_d;
  logic [1:0]       ctr_d;
  logic [TAG_W-1:0] tag_d;
  logic [31:0]      target_d;

  always_comb begin
    we       = 1'b0;
    valid_d  = valid_q[ex_idx];
    ctr_d    = ctr_q[ex_idx];
    tag_d    = tag_q[ex_idx];
    target_d = target_q[ex_idx];
    if (upd) begin
      if (ex_hit) begin
        we = 1'b1;
        if (ex_taken_i) begin
          ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_d = ex_target_i;
        end else begin
          ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken_i) begin
        we       = 1'b1;
        valid_d  = 1'b1;
        tag_d    = ex_tag;
        target_d = ex_target_i;
        ctr_d    = 2'b10;
      end
    end else if (stale_hit) begin
      we      = 1'b1;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      cti_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      if (we) begin
        valid_q[ex_idx] <= valid_d;
        ctr_q[ex_idx]   <= ctr_d;
      end
      if (upd && cti_cnt_q != 32'hFFFF_FFFF)
        cti_cnt_q <= cti_cnt_q + 32'd1;
      if (mispredict_o && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Tag/target are qualified by the valid bit, so they need no reset
  always_ff @(posedge clk_i) begin
    if (we && rst_ni) begin
      tag_q[ex_idx]    <= tag_d;
      target_q[ex_idx] <= target_d;
    end
  end

endmodule
